// File: rtl/add_tree_pkg.sv
// Shared types and helpers for the adder tree and its consumers.
package add_tree_pkg;

  localparam int unsigned EXT_MAX = 64;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  localparam int unsigned TAG_W = $bits(tag_t);

  // Extend the low 'width' bits of data to EXT_MAX bits (sign or zero fill).
  function automatic logic [EXT_MAX-1:0] ext_to(input logic [EXT_MAX-1:0] data,
                                                input logic               signed_flag,
                                                input int unsigned        width);
    logic fill;
    fill   = signed_flag & data[6'(width - 1)];
    ext_to = data;
    for (int unsigned i = 0; i < EXT_MAX; i++) begin
      if (i >= width) ext_to[6'(i)] = fill;
    end
  endfunction

endpackage

// File: rtl/add_tree_tagpipe.sv
// Enabled delay line for sideband travelling alongside the adder tree.
module add_tree_tagpipe #(
  parameter int unsigned WIDTH_TAG = 2,
  parameter int unsigned LATENCY   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clkena,
  input  logic [WIDTH_TAG-1:0] i_data,
  output logic [WIDTH_TAG-1:0] o_data
);

  if (LATENCY == 0) begin : g_pass
    logic w_unused;
    assign w_unused = &{1'b0, clk, reset, i_clkena};
    assign o_data   = i_data;
  end else begin : g_pipe
    logic [WIDTH_TAG-1:0] r_pipe [LATENCY];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
      end else if (i_clkena) begin
        r_pipe[0] <= i_data;
        for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign o_data = r_pipe[LATENCY-1];
  end

endmodule

// File: rtl/add_tree_accum.sv
// Accumulates COUNT adder-tree sums (or fewer on i_last) into one result on a
// valid/ready stream; output backpressure stalls the tree through o_clkena.
module add_tree_accum
  import add_tree_pkg::*;
#(
  parameter int unsigned WIDTH   = 11,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned COUNT   = 4,
  localparam int unsigned AW     = WIDTH + $clog2(COUNT),
  localparam int unsigned CW     = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic             i_last,
  output logic             i_ready,
  output logic             o_clkena,
  input  logic             t_signed,
  input  logic [WIDTH-1:0] t_data,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_signed,
  output logic [AW-1:0]    o_data,
  output logic [CW-1:0]    o_count
);

  logic          w_clkena;
  tag_t          w_tag_in;
  tag_t          w_tag;
  logic          w_sample;
  logic          w_first;
  logic          w_flag;
  logic [AW-1:0] w_ext;
  logic [AW-1:0] w_sum;
  logic [CW-1:0] w_cnt_inc;
  logic          w_end;

  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_flag;
  logic          r_valid;
  logic [AW-1:0] r_data;
  logic [CW-1:0] r_count;
  logic          r_signed;

  // The only stall source is a held result that downstream has not taken.
  assign w_clkena = ~r_valid | o_ready;
  assign o_clkena = w_clkena;
  assign i_ready  = w_clkena;

  assign w_tag_in = '{valid: i_valid, last: i_last};

  add_tree_tagpipe #(
    .WIDTH_TAG (TAG_W),
    .LATENCY   (LATENCY)
  ) u_tagpipe (
    .clk      (clk),
    .reset    (reset),
    .i_clkena (w_clkena),
    .i_data   (w_tag_in),
    .o_data   (w_tag)
  );

  assign w_sample  = w_tag.valid & w_clkena;
  assign w_first   = (r_cnt == '0);
  assign w_flag    = w_first ? t_signed : r_flag;
  assign w_ext     = AW'(ext_to(EXT_MAX'(t_data), w_flag, WIDTH));
  assign w_sum     = w_first ? w_ext : r_acc + w_ext;
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_end     = w_sample & ((r_cnt == CW'(COUNT - 1)) | w_tag.last);

  // Frame accumulator and sample counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_flag <= 1'b0;
    end else if (w_end) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_flag <= 1'b0;
    end else if (w_sample) begin
      r_acc  <= w_sum;
      r_cnt  <= w_cnt_inc;
      r_flag <= w_flag;
    end
  end

  // Output holding register; a frame end in the accept cycle reloads without a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_count  <= '0;
      r_signed <= 1'b0;
    end else if (w_end) begin
      r_valid  <= 1'b1;
      r_data   <= w_sum;
      r_count  <= w_cnt_inc;
      r_signed <= w_flag;
    end else if (r_valid && o_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_data   = r_data;
  assign o_count  = r_count;
  assign o_signed = r_signed;

endmodule

// File: tb/tb_add_tree_accum.sv
// Directed bench for add_tree_accum with a scoreboard of expected results.
module tb_add_tree_accum;

  localparam int unsigned WIDTH   = 11;
  localparam int unsigned LATENCY = 3;
  localparam int unsigned COUNT   = 4;
  localparam int unsigned AW      = WIDTH + $clog2(COUNT);
  localparam int unsigned CW      = $clog2(COUNT + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             i_valid, i_last, i_ready, o_clkena;
  logic             t_signed;
  logic [WIDTH-1:0] t_data;
  logic             o_valid, o_ready, o_signed;
  logic [AW-1:0]    o_data;
  logic [CW-1:0]    o_count;

  add_tree_accum #(.WIDTH(WIDTH), .LATENCY(LATENCY), .COUNT(COUNT)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_last(i_last), .i_ready(i_ready),
    .o_clkena(o_clkena), .t_signed(t_signed), .t_data(t_data), .o_valid(o_valid),
    .o_ready(o_ready), .o_signed(o_signed), .o_data(o_data), .o_count(o_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the tree: the presented sum and sign ride an enabled LATENCY-deep pipe.
  logic [WIDTH-1:0] tv_data;
  logic             tv_signed;
  logic [WIDTH:0]   tree [LATENCY];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) tree[i] <= '0;
    end else if (o_clkena) begin
      tree[0] <= {tv_signed, tv_data};
      for (int i = 1; i < LATENCY; i++) tree[i] <= tree[i-1];
    end
  end

  assign {t_signed, t_data} = tree[LATENCY-1];

  typedef struct packed {
    logic [AW-1:0] data;
    logic [CW-1:0] cnt;
    logic          sgn;
  } res_t;

  res_t sb[$];
  int   hs_cyc[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  res_t mon_exp;
  bit   ok_b;
  logic [AW-1:0] hold_d;
  logic [CW-1:0] hold_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void expect_res(input int d, input int c, input bit s);
    res_t r;
    r.data = AW'(d);
    r.cnt  = CW'(c);
    r.sgn  = s;
    sb.push_back(r);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake happens at the next rising edge; compare against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && o_valid && o_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        mon_exp = sb.pop_front();
        chk("res_data",   32'(o_data),   32'(mon_exp.data));
        chk("res_count",  32'(o_count),  32'(mon_exp.cnt));
        chk("res_signed", 32'(o_signed), 32'(mon_exp.sgn));
        hs_cyc.push_back(cyc);
      end
    end
  end

  // Present one vector and hold it until the edge that consumes it.
  task automatic send(input int d, input bit s, input bit last);
    bit ok;
    ok        = 1'b0;
    tv_data   = WIDTH'(d);
    tv_signed = s;
    i_valid   = 1'b1;
    i_last    = last;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = i_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic send_frame(input int d, input bit s);
    for (int k = 0; k < COUNT; k++) send(d, s, 1'b0);
  endtask

  task automatic drain();
    i_valid = 1'b0;
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    @(posedge clk);
    #1;
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_last = 1'b0; o_ready = 1'b1;
    tv_data = '0; tv_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",  32'(o_valid),  32'd0);
    chk("rst_data",   32'(o_data),   32'd0);
    chk("rst_count",  32'(o_count),  32'd0);
    chk("rst_signed", 32'(o_signed), 32'd0);
    chk("rst_clkena", 32'(o_clkena), 32'd1);
    reset = 1'b0;

    // Unsigned full frame
    expect_res(100, 4, 1'b0);
    send(10, 1'b0, 1'b0); send(20, 1'b0, 1'b0); send(30, 1'b0, 1'b0); send(40, 1'b0, 1'b0);
    drain();

    // Signed vs unsigned extension of all-ones, and latched frame sign
    expect_res(13'h1FFC, 4, 1'b1);
    send_frame(11'h7FF, 1'b1);
    expect_res(8188, 4, 1'b0);
    send_frame(11'h7FF, 1'b0);
    expect_res(13'h1FFC, 4, 1'b1);
    send(11'h7FF, 1'b1, 1'b0);
    send(11'h7FF, 1'b0, 1'b0); send(11'h7FF, 1'b0, 1'b0); send(11'h7FF, 1'b0, 1'b0);
    drain();

    // Early close by i_last, then a clean frame
    expect_res(12, 2, 1'b0);
    send(5, 1'b0, 1'b0); send(7, 1'b0, 1'b1);
    expect_res(4, 4, 1'b0);
    send_frame(1, 1'b0);
    drain();

    // One-sample frames: accept and reload in the same cycle keep o_valid high
    for (int k = 1; k <= 4; k++) expect_res(k, 1, 1'b0);
    for (int k = 1; k <= 4; k++) send(k, 1'b0, 1'b1);
    ok_b = 1'b0;
    for (int k = 0; k < 50 && !ok_b; k++) begin
      @(negedge clk);
      ok_b = o_valid;
    end
    for (int k = 0; k < 4; k++) begin
      chk("nobubble_valid", 32'(o_valid), 32'd1);
      @(negedge clk);
    end
    chk("nobubble_end", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    drain();

    // Back-to-back full frames: one result every COUNT cycles
    hs_cyc.delete();
    expect_res(28, 4, 1'b0); expect_res(32, 4, 1'b0); expect_res(12, 4, 1'b0);
    send_frame(7, 1'b0); send_frame(8, 1'b0); send_frame(3, 1'b0);
    drain();
    chk("b2b_results", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() == 3) begin
      chk("b2b_gap1", 32'(hs_cyc[1] - hs_cyc[0]), 32'(COUNT));
      chk("b2b_gap2", 32'(hs_cyc[2] - hs_cyc[1]), 32'(COUNT));
    end

    // Six-cycle backpressure while frames keep arriving
    expect_res(10, 4, 1'b0); expect_res(40, 4, 1'b0); expect_res(1000, 4, 1'b0);
    fork
      begin
        send(1, 1'b0, 1'b0); send(2, 1'b0, 1'b0); send(3, 1'b0, 1'b0); send(4, 1'b0, 1'b0);
        send_frame(10, 1'b0);
        send(100, 1'b0, 1'b0); send(200, 1'b0, 1'b0); send(300, 1'b0, 1'b0); send(400, 1'b0, 1'b0);
      end
      begin
        o_ready = 1'b0;
        ok_b = 1'b0;
        for (int k = 0; k < 100 && !ok_b; k++) begin
          @(negedge clk);
          ok_b = o_valid;
        end
        chk("stall_seen", 32'(ok_b), 32'd1);
        hold_d = o_data;
        hold_c = o_count;
        for (int k = 0; k < 6; k++) begin
          chk("stall_valid",  32'(o_valid),  32'd1);
          chk("stall_data",   32'(o_data),   32'(hold_d));
          chk("stall_count",  32'(o_count),  32'(hold_c));
          chk("stall_clkena", 32'(o_clkena), 32'd0);
          chk("stall_iready", 32'(i_ready),  32'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        o_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-frame: partial sum is discarded
    send(100, 1'b0, 1'b0); send(200, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rstf_valid", 32'(o_valid), 32'd0);
    chk("rstf_count", 32'(o_count), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_res(18, 4, 1'b0);
    send(3, 1'b0, 1'b0); send(4, 1'b0, 1'b0); send(5, 1'b0, 1'b0); send(6, 1'b0, 1'b0);
    drain();

    // Reset while a result is stalled
    o_ready = 1'b0;
    send_frame(9, 1'b1);
    ok_b = 1'b0;
    for (int k = 0; k < 50 && !ok_b; k++) begin
      @(negedge clk);
      ok_b = o_valid;
    end
    chk("rsts_pre_data", 32'(o_data), 32'd36);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rsts_valid",  32'(o_valid),  32'd0);
    chk("rsts_data",   32'(o_data),   32'd0);
    chk("rsts_count",  32'(o_count),  32'd0);
    chk("rsts_signed", 32'(o_signed), 32'd0);
    chk("rsts_clkena", 32'(o_clkena), 32'd1);
    sb.delete();
    @(posedge clk);
    #1;
    reset   = 1'b0;
    o_ready = 1'b1;
    expect_res(10, 4, 1'b0);
    send(1, 1'b0, 1'b0); send(2, 1'b0, 1'b0); send(3, 1'b0, 1'b0); send(4, 1'b0, 1'b0);
    drain();

    repeat (5) @(posedge clk);
    chk("final_idle", 32'(o_valid), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
